delay_buf: RTL
==============

DELAY_BUF -- requirements
Module: delay_buf

Interface
REQ-001 The block SHALL have a parameter BITS, default 64, giving the data word width.
REQ-002 The block SHALL have a parameter MAX_DEPTH, default 8, giving the maximum delay in shifts; it SHALL be at least 2 and need not be a power of two.
REQ-003 The block SHALL have a derived localparam PTR_W = $clog2(MAX_DEPTH) and DSEL_W = $clog2(MAX_DEPTH+1).
REQ-004 The block SHALL have a port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-005 The block SHALL have a port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have a port en, input, 1 bit: shift strobe that stores d and advances the buffer.
REQ-007 The block SHALL have a port flush, input, 1 bit: synchronous clear that also latches depth_sel.
REQ-008 The block SHALL have a port depth_sel, input, DSEL_W bits: requested delay, sampled only on flush.
REQ-009 The block SHALL have a port d, input, BITS bits: data shifted in.
REQ-010 The block SHALL have a port q, output, BITS bits: the oldest entry, i.e. the entry the next shift overwrites.
REQ-011 The block SHALL have a port q_vld, output, 1 bit: high when q holds data written since the last reset or flush.

Function
REQ-012 Storage SHALL be a circular buffer of MAX_DEPTH words, each with a valid bit, plus a write pointer wr_ptr (PTR_W bits) and an effective-depth register D.
REQ-013 D SHALL be MAX_DEPTH after reset; on flush, D SHALL load depth_sel, with 0 treated as 1 and values above MAX_DEPTH clamped to MAX_DEPTH.
REQ-014 On a cycle with en=1 and flush=0, the block SHALL write mem[wr_ptr]<=d and vld[wr_ptr]<=1, then set wr_ptr<=0 if wr_ptr==D-1, otherwise wr_ptr+1.
REQ-015 Wrap SHALL occur at D, not at 2^PTR_W; entries at index D or above SHALL be ignored.
REQ-016 q and q_vld SHALL be combinational from wr_ptr: q_vld=vld[wr_ptr], and q=mem[wr_ptr] when q_vld=1, otherwise all zeros.
REQ-017 A word written by shift n SHALL appear on q after shift n+D-1 and be replaced on shift n+D, giving a delay of exactly D shifts; with D=1, q SHALL show the word written by the most recent shift.
REQ-018 With en=0, all state and outputs SHALL hold, with no shift and no time-based aging.
REQ-019 A flush SHALL clear all valid bits, set wr_ptr to 0 and load D; memory data need not be cleared.
REQ-020 When flush and en are both 1, flush SHALL win and d SHALL be discarded.
REQ-021 depth_sel changes without flush SHALL have no effect.

Reset
REQ-022 Asserting rst SHALL immediately, without waiting for clk, clear all valid bits, set wr_ptr=0 and set D=MAX_DEPTH, so that q=0 and q_vld=0.
REQ-023 Reset mid-stream SHALL discard all buffered data; the first rising clk edge with rst=0 SHALL be processed normally.

Configuration
REQ-024 When the macro DELAY_BUF_STATUS_EN is defined, the block SHALL add outputs fill_cnt (DSEL_W bits) and full (1 bit).
REQ-025 With DELAY_BUF_STATUS_EN defined, fill_cnt SHALL be 0 after reset or flush and SHALL increment by 1 on each accepted shift, saturating at D.
REQ-026 With DELAY_BUF_STATUS_EN defined, full SHALL equal (fill_cnt==D), which is equivalent to q_vld.
REQ-027 When DELAY_BUF_STATUS_EN is undefined, the fill_cnt and full ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (BITS=16, MAX_DEPTH=8)
REQ-028 Reset, then shift 1..7 -> q_vld=0 and q=0 after each shift; shift 8 -> q=1, q_vld=1; shift 9 -> q=2.
REQ-029 Flush with depth_sel=3, then shift 0xA, 0xB, 0xC -> q=0xA, q_vld=1 after 0xC; shift 0xD -> q=0xB; wr_ptr never exceeds 2.
REQ-030 Flush with depth_sel=0, then shift 5 -> q=5 on the next cycle; flush with depth_sel=15 -> 7 shifts give q_vld=0 and the 8th gives q_vld=1.
REQ-031 With q_vld=1, assert flush and en together with d=0x55 -> q=0, q_vld=0, fill_cnt=0 (macro on); 8 further shifts are needed before q_vld=1, and 0x55 never appears on q.
REQ-032 With a full buffer, hold en=0 for 20 cycles -> q is stable; assert rst between clock edges -> q=0 and q_vld=0 before the next edge, and D returns to 8.
REQ-033 Compile with and without DELAY_BUF_STATUS_EN -> identical q/q_vld traces for scenarios REQ-028 to REQ-032, and fill_cnt steps 0..8 then saturates under REQ-028.

Source files
------------

// File: rtl/delay_buf.sv
// -----------------------------------------------------------------------------
// delay_buf -- programmable-depth delay line built on a circular buffer.
//
// Each accepted shift (en=1, flush=0) writes d into the slot at wr_ptr and
// advances wr_ptr, wrapping after slot D-1. The output always shows the slot
// the next shift will overwrite, i.e. the oldest word in the active window,
// so a word written on shift n is visible after shift n+D-1 and is replaced
// on shift n+D: a delay of exactly D shifts.
//
// Parameters
//   BITS       data word width
//   MAX_DEPTH  number of storage slots / largest selectable delay (>= 2)
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst        asynchronous active-high reset: clears valid bits and wr_ptr,
//              restores D = MAX_DEPTH
//   en         shift strobe: store d and advance the buffer
//   flush      synchronous clear, also loads D from depth_sel (wins over en)
//   depth_sel  requested delay; only sampled while flush is high
//   d          data shifted in
//   q          oldest entry, zero while its valid bit is clear
//   q_vld      q holds data written since the last reset or flush
//   fill_cnt   (DELAY_BUF_STATUS_EN only) number of valid entries, saturates
//              at D
//   full       (DELAY_BUF_STATUS_EN only) fill_cnt == D
//
// Configuration macro
//   DELAY_BUF_STATUS_EN  adds the fill_cnt / full status outputs and their
//                        counter. Without it those ports and that logic are
//                        absent and the data path is unchanged.
// -----------------------------------------------------------------------------
module delay_buf #(
    parameter  int BITS      = 64,
    parameter  int MAX_DEPTH = 8,
    localparam int PTR_W     = $clog2(MAX_DEPTH),
    localparam int DSEL_W    = $clog2(MAX_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic [DSEL_W-1:0] depth_sel,
    input  logic [BITS-1:0]   d,
    output logic [BITS-1:0]   q,
`ifdef DELAY_BUF_STATUS_EN
    output logic [DSEL_W-1:0] fill_cnt,
    output logic              full,
`endif
    output logic              q_vld
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [BITS-1:0]      mem_q [MAX_DEPTH];
    logic [MAX_DEPTH-1:0] vld_q,    vld_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [DSEL_W-1:0]    depth_q,  depth_d;

    logic                 shift;
    logic                 at_last;
    logic [DSEL_W-1:0]    depth_clamped;

    // A shift only happens when flush is low; flush discards d.
    assign shift = en & ~flush;

    // wr_ptr is compared against D-1 (not the pointer width) so the buffer
    // wraps at the programmed depth and slots >= D are never touched.
    assign at_last = (DSEL_W'(wr_ptr_q) == (depth_q - DSEL_W'(1)));

    // Requested depth: 0 means 1, anything above MAX_DEPTH saturates.
    always_comb begin
        depth_clamped = depth_sel;
        if (depth_sel == '0) begin
            depth_clamped = DSEL_W'(1);
        end else if (depth_sel > DSEL_W'(MAX_DEPTH)) begin
            depth_clamped = DSEL_W'(MAX_DEPTH);
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic for pointer, valid bits and depth
    // -------------------------------------------------------------------------
    always_comb begin
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        depth_d  = depth_q;
        if (flush) begin
            vld_d    = '0;
            wr_ptr_d = '0;
            depth_d  = depth_clamped;
        end else if (en) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = at_last ? '0 : (wr_ptr_q + PTR_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            depth_q  <= DSEL_W'(MAX_DEPTH);
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            depth_q  <= depth_d;
        end
    end

    // Data storage has no reset: stale words are hidden by the valid bits.
    always_ff @(posedge clk) begin
        if (shift) begin
            mem_q[wr_ptr_q] <= d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: combinational from wr_ptr, masked to zero when not valid
    // -------------------------------------------------------------------------
    assign q_vld = vld_q[wr_ptr_q];
    assign q     = q_vld ? mem_q[wr_ptr_q] : '0;

`ifdef DELAY_BUF_STATUS_EN
    // -------------------------------------------------------------------------
    // Fill counter: counts accepted shifts since reset/flush, saturating at D.
    // Once it reaches D the slot at wr_ptr has been written, so full tracks
    // q_vld.
    // -------------------------------------------------------------------------
    logic [DSEL_W-1:0] fill_q, fill_d;

    always_comb begin
        fill_d = fill_q;
        if (flush) begin
            fill_d = '0;
        end else if (en && (fill_q != depth_q)) begin
            fill_d = fill_q + DSEL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    assign fill_cnt = fill_q;
    assign full     = (fill_q == depth_q);
`endif

endmodule
